// File: rtl/half_duplex_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : half_duplex_pkg                                    |
// | Description : Shared state encoding and counter sizing helper    |
// |               for the half-duplex bus controller.                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package half_duplex_pkg;

  // 2-bit direction/turnaround state encoding
  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_TA_TX = 2'd1,
    ST_TX    = 2'd2,
    ST_TA_RX = 2'd3
  } state_t;

  // Counter must hold the larger of the two window lengths
  function automatic int cnt_width(input int ta_cyc, input int drive_cyc);
    int m;
    m = (ta_cyc > drive_cyc) ? ta_cyc : drive_cyc;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_duplex_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : half_duplex_cnt                                    |
// | Description : Loadable down-counter with done flag; saturates at |
// |               zero. Also exposes its next value so registered    |
// |               outputs can be computed one cycle ahead.           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module half_duplex_cnt
  import half_duplex_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  // Next count: load wins, otherwise decrement and hold at zero
  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_load) begin
      o_cnt_nxt = i_load_val;
    end else if (r_cnt != '0) begin
      o_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/half_duplex_bus_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : half_duplex_bus_ctrl                               |
// | Description : Direction/turnaround controller for a shared       |
// |               half-duplex line. Inserts released turnaround      |
// |               windows around every drive window.                 |
// |               Optional collision detect: HALF_DUPLEX_COLL_DET_EN |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module half_duplex_bus_ctrl
  import half_duplex_pkg::*;
#(
  parameter int W         = 8,
  parameter int TA_CYC    = 2,
  parameter int DRIVE_CYC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_valid,
  input  logic [W-1:0] tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [W-1:0] rx_data,
  output logic         bus_oe,
  output logic [W-1:0] bus_dout,
  input  logic [W-1:0] bus_din,
  output logic         bus_strobe_out,
  input  logic         bus_strobe_in,
  input  logic         coll_clr,
  output logic         coll_err
);

  localparam int            CW         = cnt_width(TA_CYC, DRIVE_CYC);
  localparam logic [CW-1:0] C_TA_LOAD  = CW'(TA_CYC - 1);
  localparam logic [CW-1:0] C_DRV_LOAD = CW'(DRIVE_CYC - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done;
  logic          w_tx_ready;
  logic          w_accept;

  logic          r_oe;
  logic          r_strobe_out;
  logic [W-1:0]  r_dout;
  logic          r_rx_valid;
  logic [W-1:0]  r_rx_data;

  half_duplex_cnt #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_cnt_nxt  (w_cnt_nxt),
    .o_done     (w_done)
  );

  // Next-state, counter load and host handshake
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = C_TA_LOAD;
    w_tx_ready  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_RX: begin
        w_tx_ready = ~rst;
        if (tx_valid && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_TA_TX;
          w_load      = 1'b1;
          w_load_val  = C_TA_LOAD;
        end
      end
      ST_TA_TX: begin
        if (w_done) begin
          w_state_nxt = ST_TX;
          w_load      = 1'b1;
          w_load_val  = C_DRV_LOAD;
        end
      end
      ST_TX: begin
        w_tx_ready = w_done;
        if (w_done) begin
          w_load = 1'b1;
          if (tx_valid) begin
            // back-to-back word: keep driving, restart the drive window
            w_accept    = 1'b1;
            w_state_nxt = ST_TX;
            w_load_val  = C_DRV_LOAD;
          end else begin
            w_state_nxt = ST_TA_RX;
            w_load_val  = C_TA_LOAD;
          end
        end
      end
      ST_TA_RX: begin
        if (w_done) begin
          w_state_nxt = ST_RX;
        end
      end
      default: begin
        w_state_nxt = ST_RX;
      end
    endcase
  end

  // State and line-side registers; outputs reflect the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RX;
      r_oe         <= 1'b0;
      r_strobe_out <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_oe         <= (w_state_nxt == ST_TX);
      r_strobe_out <= (w_state_nxt == ST_TX) && (w_cnt_nxt == '0);
      if (w_accept) begin
        r_dout <= tx_data;
      end
    end
  end

  // Receive capture, only honoured while the line is released in RX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if ((r_state == ST_RX) && bus_strobe_in) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= bus_din;
      end
    end
  end

`ifdef HALF_DUPLEX_COLL_DET_EN
  logic r_coll_err;

  // Sticky collision flag: peer strobed while we were not listening; set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll_err <= 1'b0;
    end else if (bus_strobe_in && (r_state != ST_RX)) begin
      r_coll_err <= 1'b1;
    end else if (coll_clr) begin
      r_coll_err <= 1'b0;
    end
  end

  assign coll_err = r_coll_err;
`else
  logic w_unused_coll_clr;
  assign w_unused_coll_clr = coll_clr;
  assign coll_err          = 1'b0;
`endif

  assign tx_ready       = w_tx_ready;
  assign rx_valid       = r_rx_valid;
  assign rx_data        = r_rx_data;
  assign bus_oe         = r_oe;
  assign bus_dout       = r_dout;
  assign bus_strobe_out = r_strobe_out;

endmodule
`default_nettype wire
